bram_ld_buffer: RTL

Elastic load-stream buffer between the global buffer (BRAM) load port and the compute-tile ingress. The BRAM reacts to nack only after a registered delay, so words keep arriving after nack is raised. This block absorbs those in-flight words in a small FIFO and raises nack early enough that none are lost. It also tracks stream framing (acquire word, release word) and reports occupancy and errors.

---
 rtl/bram_ld_buffer_pkg.sv | 33 +++
 rtl/bram_ld_buffer_fifo.sv | 66 ++++++
 rtl/bram_ld_buffer.sv | 91 +++++++++
 3 files changed

// File: rtl/bram_ld_buffer_pkg.sv
// Shared token types for the BRAM load path and the load-buffer framing FSM.
package pkg_en;

  typedef struct packed {
    logic        v;
    logic        a;
    logic        r;
    logic        c;
    logic [7:0]  i;
    logic [31:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

endpackage

package pkg_bram_if;

  // Words the BRAM still emits after nack: registered nack + LdEn stage + read-data stage.
  localparam int BRAM_LD_SLACK = 3;

  typedef enum logic [1:0] {
    LDB_IDLE,
    LDB_STREAM,
    LDB_DRAIN
  } fsm_bram_ldbuf;

endpackage

// File: rtl/bram_ld_buffer_fifo.sv
// Synchronous FTk_t FIFO whose head is read straight from storage flops (no bypass path).
module bram_ld_fifo
  import pkg_en::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH_CNT = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  FTk_t                 data_i,
  output FTk_t                 head_o,
  output logic [WIDTH_CNT-1:0] count_o,
  output logic [WIDTH_CNT-1:0] count_next_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PW = $clog2(DEPTH);

  FTk_t                 mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [WIDTH_CNT-1:0] count_q;

  assign count_o = count_q;
  assign full_o  = (count_q == WIDTH_CNT'(DEPTH));
  assign empty_o = (count_q == '0);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_next_o = count_q;
    case ({push_i, pop_i})
      2'b10:   count_next_o = count_q + WIDTH_CNT'(1);
      2'b01:   count_next_o = count_q - WIDTH_CNT'(1);
      default: count_next_o = count_q;
    endcase
  end

  always_comb begin
    head_o = '0;
    if (!empty_o) begin
      head_o   = mem_q[rd_ptr_q];
      head_o.v = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_next_o;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never seen.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bram_ld_buffer.sv
// Elastic BRAM load buffer: absorbs in-flight words after nack, tracks acquire/release framing.
module bram_ld_buffer
  import pkg_en::*;
  import pkg_bram_if::*;
#(
  parameter int DEPTH     = 8,
  parameter int SLACK     = BRAM_LD_SLACK,
  parameter int WIDTH_CNT = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  FTk_t                 I_FTk,
  output BTk_t                 O_BTk,
  output FTk_t                 O_FTk,
  input  BTk_t                 I_BTk,
  output logic [WIDTH_CNT-1:0] O_Count,
  output logic                 O_Busy,
  output logic                 O_Err
);

  fsm_bram_ldbuf        state_q;
  logic                 nack_q;
  logic                 err_q;

  FTk_t                 head;
  logic [WIDTH_CNT-1:0] count;
  logic [WIDTH_CNT-1:0] count_next;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push;
  logic                 in_window;
  logic                 overflow;
  logic                 drain_drop;
  logic                 unused_btk;

  assign pop        = head.v & ~I_BTk.n;
  assign in_window  = I_FTk.v & (state_q != LDB_DRAIN);
  assign push       = in_window & (~full | pop);
  assign overflow   = in_window & full & ~pop;
  assign drain_drop = I_FTk.v & (state_q == LDB_DRAIN);
  assign unused_btk = ^{I_BTk.v, I_BTk.c};

  bram_ld_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH_CNT (WIDTH_CNT)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .data_i       (I_FTk),
    .head_o       (head),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (full),
    .empty_o      (empty)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LDB_IDLE;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Nack leads the FIFO by SLACK entries so the BRAM's in-flight words always fit.
      nack_q <= (DEPTH - int'(count_next)) <= SLACK;
      if (overflow || drain_drop) err_q <= 1'b1;
      case (state_q)
        LDB_IDLE: begin
          if (push && I_FTk.a) state_q <= I_FTk.r ? LDB_DRAIN : LDB_STREAM;
        end
        LDB_STREAM: begin
          if (I_BTk.t || (push && I_FTk.r)) state_q <= LDB_DRAIN;
        end
        LDB_DRAIN: begin
          if (empty || ((count == WIDTH_CNT'(1)) && pop)) state_q <= LDB_IDLE;
        end
        default: state_q <= LDB_IDLE;
      endcase
    end
  end

  assign O_BTk   = '{n: nack_q, t: I_BTk.t, v: 1'b0, c: 1'b0};
  assign O_FTk   = head;
  assign O_Count = count;
  assign O_Busy  = (state_q != LDB_IDLE) | ~empty;
  assign O_Err   = err_q;

endmodule
